adc_burst_scheduler: RTL

ADC_BURST_SCHEDULER -- requirements
Module: adc_burst_scheduler

---
 rtl/adc_burst_scheduler.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/adc_burst_scheduler.sv
// Burst scheduler for a 12-bit serial ADC behind an LT5534 detector.
// Define LOCTAG_ADC_AVG_EN to report the mean of every 4 conversions.
module adc_burst_scheduler #(
    parameter int HALF_DIV      = 2,
    parameter int SETTLE_CYCLES = 50,
    parameter int SAMPLE_PERIOD = 100,
    parameter int BURST_LEN     = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        trig,
    input  logic        force_fs,
    output logic        lt5534_en,
    output logic        adc_cs,
    output logic        adc_clk,
    input  logic        adc_so,
    output logic [11:0] sample_data,
    output logic        sample_valid,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        POWER_UP,
        CONVERT,
        GAP
    } state_t;

    localparam int PW = $clog2(SAMPLE_PERIOD + SETTLE_CYCLES + 1);
    localparam int HW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam int RW = $clog2(BURST_LEN + 1);

    localparam logic [PW-1:0] P_LAST = PW'(SAMPLE_PERIOD - 1);
    localparam logic [PW-1:0] S_LAST = PW'(SETTLE_CYCLES - 1);
    localparam logic [HW-1:0] H_LAST = HW'(HALF_DIV - 1);
    localparam logic [RW-1:0] R_LOAD = RW'(BURST_LEN);

    state_t        state, nxt;
    logic [PW-1:0] pcnt;
    logic [HW-1:0] hcnt;
    logic [5:0]    ecnt;
    logic [RW-1:0] rem;
    logic [15:0]   sh;
    logic [3:0]    lead_unused;

    logic half_end, rise, frame_end;

    // ecnt counts adc_clk half-periods; odd values are the low halves
    assign half_end  = (hcnt == H_LAST);
    assign rise      = (state == CONVERT) && half_end && ecnt[0];
    assign frame_end = (state == CONVERT) && half_end && (ecnt == 6'd32);

    assign lt5534_en   = (state != IDLE);
    assign busy        = (state != IDLE);
    assign adc_cs      = (state != CONVERT);
    assign adc_clk     = ~ecnt[0];
    assign lead_unused = sh[15:12];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:     if (trig || force_fs) nxt = POWER_UP;
            POWER_UP: if (pcnt == S_LAST) nxt = CONVERT;
            CONVERT:  if (frame_end) nxt = GAP;
            GAP: begin
                if (pcnt == P_LAST)
                    nxt = (force_fs || rem != '0) ? CONVERT : IDLE;
            end
            default:  nxt = IDLE;
        endcase
    end

    // pcnt keeps running from cs fall through GAP to pace the period
    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt <= '0;
            hcnt <= '0;
            ecnt <= '0;
            rem  <= '0;
            sh   <= '0;
        end else begin
            if (nxt == IDLE || (nxt != state && nxt != GAP))
                pcnt <= '0;
            else
                pcnt <= pcnt + 1'b1;

            if (state == CONVERT && !frame_end) begin
                hcnt <= half_end ? '0 : hcnt + 1'b1;
                if (half_end) ecnt <= ecnt + 6'd1;
            end else begin
                hcnt <= '0;
                ecnt <= '0;
            end

            if (state == IDLE)
                rem <= trig ? R_LOAD : '0;
            else if (trig)
                rem <= R_LOAD;
            else if (frame_end && rem != '0)
                rem <= rem - 1'b1;

            if (rise) sh <= {sh[14:0], adc_so};
        end
    end

`ifdef LOCTAG_ADC_AVG_EN
    logic [13:0] sum;
    logic [13:0] acc;
    logic [1:0]  grp;

    assign acc = sum + 14'(sh[11:0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            sum          <= '0;
            grp          <= '0;
            sample_data  <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (state == IDLE) begin
                sum <= '0;
                grp <= '0;
            end else if (frame_end) begin
                grp <= grp + 2'd1;
                if (grp == 2'd3) begin
                    sample_data  <= acc[13:2];
                    sample_valid <= 1'b1;
                    sum          <= '0;
                end else begin
                    sum <= acc;
                end
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_data  <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= frame_end;
            if (frame_end) sample_data <= sh[11:0];
        end
    end
`endif

endmodule
